// File: rtl/serial_even_parity_checker.sv
// Serial even-parity frame receiver: start, DATA_W data bits LSB first,
// parity and stop bit, one bit per clock, reported as a parallel word.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sin        serial line, idle high
//   data_out   last received data word
//   valid      one-cycle pulse when a new frame result is available
//   parity_err last frame failed the even parity check
//   frame_err  last frame had a stop bit of 0
//   busy       high while a frame is in progress
module serial_even_parity_checker #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              acc, acc_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              perr, perr_n;
    logic [DATA_W-1:0] dout_n;
    logic              pe_n, fe_n, valid_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= 1'b0;
            sh         <= '0;
            perr       <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            acc        <= acc_n;
            sh         <= sh_n;
            perr       <= perr_n;
            data_out   <= dout_n;
            parity_err <= pe_n;
            frame_err  <= fe_n;
            valid      <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        sh_n    = sh;
        perr_n  = perr;
        dout_n  = data_out;
        pe_n    = parity_err;
        fe_n    = frame_err;
        valid_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (!sin) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    acc_n   = 1'b0;
                end
            end
            DATA: begin
                // Bits arrive LSB first: enter at the MSB end and shift
                // down so the first bit lands in bit 0 after DATA_W shifts.
                sh_n  = DATA_W'({sin, sh} >> 1);
                acc_n = acc ^ sin;
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(DATA_W - 1))
                    state_n = PARITY;
            end
            PARITY: begin
                perr_n  = acc ^ sin;
                state_n = STOP;
            end
            STOP: begin
                // All result fields update together with the valid pulse.
                dout_n  = sh;
                pe_n    = perr;
                fe_n    = ~sin;
                valid_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_even_parity_checker.sv
// Self-checking bench for serial_even_parity_checker: directed frames from
// the test plan followed by random frames, checked every cycle.
module tb_serial_even_parity_checker;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         sin;
    logic [W-1:0] data_out;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Reference: the most recently completed frame's expected result.
    logic [W-1:0] last_d;
    logic         last_pe;
    logic         last_fe;

    serial_even_parity_checker #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic ev, input logic eb);
        chk("valid", {31'd0, valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("data_out", {28'd0, data_out}, {28'd0, last_d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, last_pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, last_fe});
    endtask

    // Drive one bit, let it be sampled, then check at the falling edge.
    task automatic cycle(input logic b, input logic ev, input logic eb);
        sin = b;
        @(posedge clk);
        @(negedge clk);
        check_all(ev, eb);
    endtask

    task automatic send(input logic [W-1:0] d, input logic p,
                        input logic s);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W; i++)
            cycle(d[i], 1'b0, 1'b1);
        cycle(p, 1'b0, 1'b1);
        last_d  = d;
        last_pe = (^d) ^ p;
        last_fe = ~s;
        cycle(s, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rp;
        logic         rs;
        last_d  = '0;
        last_pe = 1'b0;
        last_fe = 1'b0;
        sin = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all(1'b0, 1'b0);
        rst = 1'b0;
        idle(3);

        send(4'b1011, 1'b1, 1'b1);
        idle(2);
        send(4'b0110, 1'b1, 1'b1);
        idle(1);
        send(4'b0001, 1'b1, 1'b0);
        send(4'b1100, 1'b0, 1'b1);
        idle(2);

        send(4'hA, 1'b0, 1'b1);
        send(4'h5, 1'b0, 1'b1);
        idle(2);

        // Abort mid-frame with an asynchronous reset between edges.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        last_d  = '0;
        last_pe = 1'b0;
        last_fe = 1'b0;
        check_all(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        send(4'h3, 1'b0, 1'b1);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            rd = W'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rd, rp, rs);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
